// File: rtl/etapa_decode_pkg.sv
// Shared decode constants for the MIPS-subset pipeline: opcodes, R-type funct
// codes, ALU control codes and the decoded control bundle.
package decode_pkg;

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_J     = 6'd2;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_BNE   = 6'd5;
    localparam logic [5:0] OP_ADDI  = 6'd8;
    localparam logic [5:0] OP_SLTI  = 6'd10;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SW    = 6'd43;

    localparam logic [5:0] F_ADD = 6'h20;
    localparam logic [5:0] F_SUB = 6'h22;
    localparam logic [5:0] F_AND = 6'h24;
    localparam logic [5:0] F_OR  = 6'h25;
    localparam logic [5:0] F_SLT = 6'h2A;

    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_AND = 4'd2,
        ALU_OR  = 4'd3,
        ALU_SLT = 4'd4
    } alu_ctrl_e;

    typedef struct packed {
        logic      reg_write;
        logic      mem_read;
        logic      mem_write;
        logic      mem_to_reg;
        logic      alu_src;
        alu_ctrl_e alu_ctrl;
        logic      illegal;
    } ctrl_t;

endpackage

// File: rtl/etapa_decode_banco_registros.sv
// Register file: two asynchronous read ports with same-cycle write-through,
// one synchronous write port; register 0 is hardwired to zero.
module banco_registros #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [REG_AW-1:0] rs_addr_i,
    input  logic [REG_AW-1:0] rt_addr_i,
    output logic [DATA_W-1:0] rs_data_o,
    output logic [DATA_W-1:0] rt_data_o,
    input  logic              we_i,
    input  logic [REG_AW-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i
);

    logic [DATA_W-1:0] regs_q [2**REG_AW];
    logic              write_s;

    // A write held off by reset must not be forwarded either.
    assign write_s = we_i & ~rst_i & (wr_addr_i != '0);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < 2**REG_AW; i++) begin
                regs_q[i] <= '0;
            end
        end else if (write_s) begin
            regs_q[wr_addr_i] <= wr_data_i;
        end
    end

    always_comb begin
        rs_data_o = '0;
        if (rs_addr_i == '0) begin
            rs_data_o = '0;
        end else if (write_s && (wr_addr_i == rs_addr_i)) begin
            rs_data_o = wr_data_i;
        end else begin
            rs_data_o = regs_q[rs_addr_i];
        end
    end

    always_comb begin
        rt_data_o = '0;
        if (rt_addr_i == '0) begin
            rt_data_o = '0;
        end else if (write_s && (wr_addr_i == rt_addr_i)) begin
            rt_data_o = wr_data_i;
        end else begin
            rt_data_o = regs_q[rt_addr_i];
        end
    end

endmodule

// File: rtl/etapa_decode.sv
// Decode stage: IF/ID register, register-file read, branch/jump resolution fed
// back to fetch, and the registered ID/EX slot presented to execute.
module etapa_decode
    import decode_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       instruction_in,
    input  logic [31:0]       pc4_in,
    input  logic              stall,
    input  logic              wb_we,
    input  logic [REG_AW-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic [31:0]       signal_extended,
    output logic              be,
    output logic [25:0]       j_address,
    output logic              jump,
    output logic              ex_valid,
    output logic [31:0]       ex_pc4,
    output logic [DATA_W-1:0] ex_rs_val,
    output logic [DATA_W-1:0] ex_rt_val,
    output logic [DATA_W-1:0] ex_imm,
    output logic [REG_AW-1:0] ex_dest,
    output logic              ex_reg_write,
    output logic              ex_mem_read,
    output logic              ex_mem_write,
    output logic              ex_mem_to_reg,
    output logic              ex_alu_src,
    output logic [3:0]        ex_alu_ctrl,
    output logic              ex_illegal
);

    logic [31:0]       ifid_instr_q, ifid_instr_d;
    logic [31:0]       ifid_pc4_q, ifid_pc4_d;
    logic              ifid_valid_q, ifid_valid_d;

    logic [5:0]        op_s, funct_s;
    logic [REG_AW-1:0] rs_s, rt_s, rd_s, dest_s;
    logic [15:0]       imm_s;
    logic [DATA_W-1:0] sext_s, rs_val_s, rt_val_s;
    logic              flush_s;
    ctrl_t             ctrl_s;

    ctrl_t             ex_ctrl_q, ex_ctrl_d;
    logic              ex_valid_q, ex_valid_d;
    logic [31:0]       ex_pc4_q, ex_pc4_d;
    logic [DATA_W-1:0] ex_rs_q, ex_rs_d, ex_rt_q, ex_rt_d, ex_imm_q, ex_imm_d;
    logic [REG_AW-1:0] ex_dest_q, ex_dest_d;

    assign op_s    = ifid_instr_q[31:26];
    assign rs_s    = ifid_instr_q[25:21];
    assign rt_s    = ifid_instr_q[20:16];
    assign rd_s    = ifid_instr_q[15:11];
    assign funct_s = ifid_instr_q[5:0];
    assign imm_s   = ifid_instr_q[15:0];
    assign sext_s  = {{(DATA_W-16){imm_s[15]}}, imm_s};
    assign dest_s  = (op_s == OP_RTYPE) ? rd_s : rt_s;
    assign flush_s = be | jump;

    banco_registros #(
        .DATA_W (DATA_W),
        .REG_AW (REG_AW)
    ) u_banco (
        .clk_i     (clk),
        .rst_i     (rst),
        .rs_addr_i (rs_s),
        .rt_addr_i (rt_s),
        .rs_data_o (rs_val_s),
        .rt_data_o (rt_val_s),
        .we_i      (wb_we),
        .wr_addr_i (wb_addr),
        .wr_data_i (wb_data)
    );

    // Feedback to fetch is forced quiet while reset is asserted.
    always_comb begin
        signal_extended = 32'd0;
        j_address       = 26'd0;
        be              = 1'b0;
        jump            = 1'b0;
        if (rst) begin
            signal_extended = 32'd0;
        end else begin
            signal_extended = sext_s;
            j_address       = ifid_instr_q[25:0];
            if (ifid_valid_q && !stall) begin
                be   = ((op_s == OP_BEQ) && (rs_val_s == rt_val_s)) ||
                       ((op_s == OP_BNE) && (rs_val_s != rt_val_s));
                jump = (op_s == OP_J);
            end else begin
                be   = 1'b0;
                jump = 1'b0;
            end
        end
    end

    always_comb begin
        ifid_instr_d = ifid_instr_q;
        ifid_pc4_d   = ifid_pc4_q;
        ifid_valid_d = ifid_valid_q;
        if (rst) begin
            ifid_instr_d = 32'd0;
            ifid_pc4_d   = 32'd0;
            ifid_valid_d = 1'b0;
        end else if (stall) begin
            ifid_valid_d = ifid_valid_q;
        end else if (flush_s) begin
            ifid_instr_d = 32'd0;
            ifid_valid_d = 1'b0;
        end else begin
            ifid_instr_d = instruction_in;
            ifid_pc4_d   = pc4_in;
            ifid_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        ifid_instr_q <= ifid_instr_d;
        ifid_pc4_q   <= ifid_pc4_d;
        ifid_valid_q <= ifid_valid_d;
    end

    // Branches, jumps and the all-zero NOP decode to inert slots.
    always_comb begin
        ctrl_s = '0;
        if (!ifid_valid_q) begin
            ctrl_s = '0;
        end else begin
            case (op_s)
                OP_RTYPE: begin
                    if (ifid_instr_q == 32'd0) begin
                        ctrl_s = '0;
                    end else begin
                        ctrl_s.reg_write = 1'b1;
                        case (funct_s)
                            F_ADD:   ctrl_s.alu_ctrl = ALU_ADD;
                            F_SUB:   ctrl_s.alu_ctrl = ALU_SUB;
                            F_AND:   ctrl_s.alu_ctrl = ALU_AND;
                            F_OR:    ctrl_s.alu_ctrl = ALU_OR;
                            F_SLT:   ctrl_s.alu_ctrl = ALU_SLT;
                            default: begin
                                ctrl_s         = '0;
                                ctrl_s.illegal = 1'b1;
                            end
                        endcase
                    end
                end
                OP_ADDI: begin
                    ctrl_s.reg_write = 1'b1;
                    ctrl_s.alu_src   = 1'b1;
                    ctrl_s.alu_ctrl  = ALU_ADD;
                end
                OP_SLTI: begin
                    ctrl_s.reg_write = 1'b1;
                    ctrl_s.alu_src   = 1'b1;
                    ctrl_s.alu_ctrl  = ALU_SLT;
                end
                OP_LW: begin
                    ctrl_s.reg_write  = 1'b1;
                    ctrl_s.mem_read   = 1'b1;
                    ctrl_s.mem_to_reg = 1'b1;
                    ctrl_s.alu_src    = 1'b1;
                    ctrl_s.alu_ctrl   = ALU_ADD;
                end
                OP_SW: begin
                    ctrl_s.mem_write = 1'b1;
                    ctrl_s.alu_src   = 1'b1;
                    ctrl_s.alu_ctrl  = ALU_ADD;
                end
                OP_BEQ, OP_BNE, OP_J: ctrl_s = '0;
                default: ctrl_s.illegal = 1'b1;
            endcase
        end
    end

    always_comb begin
        ex_ctrl_d  = '0;
        ex_valid_d = 1'b0;
        ex_pc4_d   = 32'd0;
        ex_rs_d    = '0;
        ex_rt_d    = '0;
        ex_imm_d   = '0;
        ex_dest_d  = '0;
        if (rst || stall) begin
            ex_valid_d = 1'b0;
        end else begin
            ex_ctrl_d  = ctrl_s;
            ex_valid_d = ifid_valid_q;
            ex_pc4_d   = ifid_pc4_q;
            ex_rs_d    = rs_val_s;
            ex_rt_d    = rt_val_s;
            ex_imm_d   = sext_s;
            ex_dest_d  = dest_s;
        end
    end

    always_ff @(posedge clk) begin
        ex_ctrl_q  <= ex_ctrl_d;
        ex_valid_q <= ex_valid_d;
        ex_pc4_q   <= ex_pc4_d;
        ex_rs_q    <= ex_rs_d;
        ex_rt_q    <= ex_rt_d;
        ex_imm_q   <= ex_imm_d;
        ex_dest_q  <= ex_dest_d;
    end

    assign ex_valid      = ex_valid_q;
    assign ex_pc4        = ex_pc4_q;
    assign ex_rs_val     = ex_rs_q;
    assign ex_rt_val     = ex_rt_q;
    assign ex_imm        = ex_imm_q;
    assign ex_dest       = ex_dest_q;
    assign ex_reg_write  = ex_ctrl_q.reg_write;
    assign ex_mem_read   = ex_ctrl_q.mem_read;
    assign ex_mem_write  = ex_ctrl_q.mem_write;
    assign ex_mem_to_reg = ex_ctrl_q.mem_to_reg;
    assign ex_alu_src    = ex_ctrl_q.alu_src;
    assign ex_alu_ctrl   = ex_ctrl_q.alu_ctrl;
    assign ex_illegal    = ex_ctrl_q.illegal;

endmodule

// File: tb/tb_etapa_decode.sv
// Self-checking bench for etapa_decode: directed scenarios with literal
// expectations, then randomized traffic against a behavioural pipeline model.
module tb_etapa_decode;

    logic        clk = 1'b0;
    logic        rst, stall, wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data, instruction_in, pc4_in;
    logic [31:0] signal_extended;
    logic        be, jump;
    logic [25:0] j_address;
    logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;
    logic        ex_alu_src, ex_illegal;
    logic [31:0] ex_pc4, ex_rs_val, ex_rt_val, ex_imm;
    logic [4:0]  ex_dest;
    logic [3:0]  ex_alu_ctrl;

    int checks = 0;
    int errors = 0;

    // Model state: architectural registers and the instruction sitting in decode
    logic [31:0] m_regs [32];
    logic [31:0] m_instr = 32'd0;
    logic [31:0] m_pc4   = 32'd0;
    logic        m_valid = 1'b0;

    logic        last_be, last_jump;
    logic [31:0] last_se;
    logic [25:0] last_ja;

    always #5 clk = ~clk;

    etapa_decode dut (
        .clk             (clk),
        .rst             (rst),
        .instruction_in  (instruction_in),
        .pc4_in          (pc4_in),
        .stall           (stall),
        .wb_we           (wb_we),
        .wb_addr         (wb_addr),
        .wb_data         (wb_data),
        .signal_extended (signal_extended),
        .be              (be),
        .j_address       (j_address),
        .jump            (jump),
        .ex_valid        (ex_valid),
        .ex_pc4          (ex_pc4),
        .ex_rs_val       (ex_rs_val),
        .ex_rt_val       (ex_rt_val),
        .ex_imm          (ex_imm),
        .ex_dest         (ex_dest),
        .ex_reg_write    (ex_reg_write),
        .ex_mem_read     (ex_mem_read),
        .ex_mem_write    (ex_mem_write),
        .ex_mem_to_reg   (ex_mem_to_reg),
        .ex_alu_src      (ex_alu_src),
        .ex_alu_ctrl     (ex_alu_ctrl),
        .ex_illegal      (ex_illegal)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mread(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (wb_we && (wb_addr == a)) return wb_data;
        return m_regs[a];
    endfunction

    // Control word {reg_write, mem_read, mem_write, mem_to_reg, alu_src, alu_ctrl[3:0], illegal}
    function automatic logic [9:0] model_decode(input logic [31:0] ins);
        logic [9:0] cw;
        cw = 10'b00000_0000_1;
        if (ins == 32'd0) begin
            cw = 10'd0;
        end else begin
            case (ins[31:26])
                6'd0: begin
                    case (ins[5:0])
                        6'h20: cw = {5'b10000, 4'd0, 1'b0};
                        6'h22: cw = {5'b10000, 4'd1, 1'b0};
                        6'h24: cw = {5'b10000, 4'd2, 1'b0};
                        6'h25: cw = {5'b10000, 4'd3, 1'b0};
                        6'h2A: cw = {5'b10000, 4'd4, 1'b0};
                        default: cw = 10'b00000_0000_1;
                    endcase
                end
                6'd8:  cw = {5'b10001, 4'd0, 1'b0};
                6'd10: cw = {5'b10001, 4'd4, 1'b0};
                6'd35: cw = {5'b11011, 4'd0, 1'b0};
                6'd43: cw = {5'b00101, 4'd0, 1'b0};
                6'd2, 6'd4, 6'd5: cw = 10'd0;
                default: cw = 10'b00000_0000_1;
            endcase
        end
        return cw;
    endfunction

    // One clock: drive inputs, check fetch feedback, advance model, check ID/EX.
    task automatic cycle(input logic r, input logic st, input logic we, input logic [4:0] wa,
                         input logic [31:0] wd, input logic [31:0] ins, input logic [31:0] pc);
        logic [5:0]  op;
        logic [31:0] rsv, rtv, se;
        logic [9:0]  cw;
        logic        eb, ej, e_valid, e_data;
        logic [31:0] e_pc4, e_rs, e_rt, e_imm;
        logic [4:0]  e_dest;
        @(negedge clk);
        rst = r; stall = st; wb_we = we; wb_addr = wa; wb_data = wd;
        instruction_in = ins; pc4_in = pc;
        #1;
        op  = m_instr[31:26];
        rsv = mread(m_instr[25:21]);
        rtv = mread(m_instr[20:16]);
        se  = {{16{m_instr[15]}}, m_instr[15:0]};
        eb  = !r && m_valid && !st && ((op == 6'd4 && rsv == rtv) || (op == 6'd5 && rsv != rtv));
        ej  = !r && m_valid && !st && (op == 6'd2);
        check("be", 32'(be), 32'(eb));
        check("jump", 32'(jump), 32'(ej));
        check("signal_extended", signal_extended, r ? 32'd0 : se);
        check("j_address", 32'(j_address), r ? 32'd0 : 32'(m_instr[25:0]));
        last_be = be; last_jump = jump; last_se = signal_extended; last_ja = j_address;

        cw = 10'd0; e_valid = 1'b0; e_data = 1'b1;
        e_pc4 = 32'd0; e_rs = 32'd0; e_rt = 32'd0; e_imm = 32'd0; e_dest = 5'd0;
        if (!(r || st)) begin
            e_valid = m_valid;
            e_data  = m_valid;
            cw      = m_valid ? model_decode(m_instr) : 10'd0;
            e_pc4   = m_pc4; e_rs = rsv; e_rt = rtv; e_imm = se;
            e_dest  = (op == 6'd0) ? m_instr[15:11] : m_instr[20:16];
        end

        if (r) begin
            for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
            m_instr = 32'd0; m_pc4 = 32'd0; m_valid = 1'b0;
        end else begin
            if (we && wa != 5'd0) m_regs[wa] = wd;
            if (!st) begin
                if (eb || ej) begin
                    m_instr = 32'd0; m_valid = 1'b0;
                end else begin
                    m_instr = ins; m_pc4 = pc; m_valid = 1'b1;
                end
            end
        end

        @(posedge clk);
        #1;
        check("ex_valid", 32'(ex_valid), 32'(e_valid));
        check("ex_ctrl", 32'({ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg,
                              ex_alu_src, ex_alu_ctrl, ex_illegal}), 32'(cw));
        if (e_data) begin
            check("ex_pc4", ex_pc4, e_pc4);
            check("ex_rs_val", ex_rs_val, e_rs);
            check("ex_rt_val", ex_rt_val, e_rt);
            check("ex_imm", ex_imm, e_imm);
        end
        if (cw[9] || r || st) check("ex_dest", 32'(ex_dest), 32'(e_dest));
    endtask

    function automatic logic [31:0] rand_instr();
        logic [4:0]  rs_f, rt_f, rd_f;
        logic [15:0] imm;
        logic [5:0]  fl [6];
        fl   = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h07};
        rs_f = 5'($urandom_range(0, 7));
        rt_f = 5'($urandom_range(0, 7));
        rd_f = 5'($urandom_range(0, 7));
        imm  = 16'($urandom);
        case ($urandom_range(0, 10))
            1:  return {6'd8, rs_f, rt_f, imm};
            2:  return {6'd10, rs_f, rt_f, imm};
            3:  return {6'd35, rs_f, rt_f, imm};
            4:  return {6'd43, rs_f, rt_f, imm};
            5:  return {6'd4, rs_f, rt_f, imm};
            6:  return {6'd5, rs_f, rt_f, imm};
            7:  return {6'd2, 26'($urandom)};
            8:  return $urandom;
            9:  return 32'd0;
            default: return {6'd0, rs_f, rt_f, rd_f, 5'd0, fl[$urandom_range(0, 5)]};
        endcase
    endfunction

    initial begin
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        rst = 1'b1; stall = 1'b0; wb_we = 1'b0; wb_addr = 5'd0; wb_data = 32'd0;
        instruction_in = 32'd0; pc4_in = 32'd0;

        // Reset with a pending write that must be dropped
        cycle(1'b1, 1'b0, 1'b1, 5'd5, 32'hFFFF_FFFF, 32'h0022_1820, 32'd4);
        cycle(1'b1, 1'b0, 1'b1, 5'd5, 32'hFFFF_FFFF, 32'h0022_1820, 32'd4);
        check("rst_ex_valid", 32'(ex_valid), 32'd0);
        check("rst_reg_write", 32'(ex_reg_write), 32'd0);
        check("rst_be", 32'(last_be), 32'd0);

        // Writeback then add $3,$1,$2
        cycle(1'b0, 1'b0, 1'b1, 5'd1, 32'd7, 32'd0, 32'd8);
        cycle(1'b0, 1'b0, 1'b1, 5'd2, 32'd5, 32'd0, 32'd12);
        cycle(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'h0022_1820, 32'd16);
        cycle(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 32'd20);
        check("add_rs", ex_rs_val, 32'd7);
        check("add_rt", ex_rt_val, 32'd5);
        check("add_dest", 32'(ex_dest), 32'd3);
        check("add_reg_write", 32'(ex_reg_write), 32'd1);
        check("add_alu_ctrl", 32'(ex_alu_ctrl), 32'd0);

        // add $6,$5,$0: $5 must still be zero after the dropped reset write
        cycle(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'h00A0_3020, 32'd24);
        cycle(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 32'd28);
        check("reg5_zero", ex_rs_val, 32'd0);

        // sw $4,8($0) with $4 written in the same cycle
        cycle(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'hAC04_0008, 32'd32);
        cycle(1'b0, 1'b0, 1'b1, 5'd4, 32'h1234, 32'd0, 32'd36);
        check("byp_rt", ex_rt_val, 32'h1234);
        check("byp_imm", ex_imm, 32'd8);
        check("byp_mem_write", 32'(ex_mem_write), 32'd1);

        // beq $1,$2,-3 taken once $2 equals $1
        cycle(1'b0, 1'b0, 1'b1, 5'd2, 32'd7, 32'd0, 32'd40);
        cycle(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'h1022_FFFD, 32'd44);
        cycle(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'h2003_0001, 32'd48);
        check("beq_be", 32'(last_be), 32'd1);
        check("beq_sext", last_se, 32'hFFFF_FFFD);
        check("beq_inert", 32'({ex_valid, ex_reg_write, ex_mem_write}), 32'b100);
        cycle(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 32'd52);
        check("beq_flushed", 32'(ex_valid), 32'd0);

        // Stall with lw $5,4($0) in decode and a beq on the input
        cycle(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'h8C05_0004, 32'd56);
        cycle(1'b0, 1'b1, 1'b0, 5'd0, 32'd0, 32'h1022_FFFD, 32'd60);
        check("stall_bubble", 32'(ex_valid), 32'd0);
        check("stall_be", 32'(last_be), 32'd0);
        cycle(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 32'd64);
        check("lw_valid", 32'(ex_valid), 32'd1);
        check("lw_mem_read", 32'(ex_mem_read), 32'd1);
        check("lw_dest", 32'(ex_dest), 32'd5);
        check("lw_pc4", ex_pc4, 32'd56);

        // j 0x100, then an unsupported opcode
        cycle(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'h0800_0100, 32'd68);
        cycle(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'hFC00_0000, 32'd72);
        check("j_jump", 32'(last_jump), 32'd1);
        check("j_addr", 32'(last_ja), 32'h100);
        cycle(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'hFC00_0000, 32'd76);
        check("j_flushed", 32'(ex_valid), 32'd0);
        cycle(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 32'd80);
        check("ill_flag", 32'(ex_illegal), 32'd1);
        check("ill_ctrl", 32'({ex_reg_write, ex_mem_read, ex_mem_write, ex_alu_src}), 32'd0);

        // Randomized traffic including mid-stream resets
        for (int n = 0; n < 400; n++) begin
            cycle(1'($urandom_range(0, 99) == 0),
                  1'($urandom_range(0, 99) < 15),
                  1'($urandom_range(0, 1)),
                  5'($urandom_range(0, 7)),
                  ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 3)) : $urandom,
                  rand_instr(),
                  32'(84 + 4 * n));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
